// File: rtl/agu_lsq.sv
// agu_lsq: in-order load/store queue fed at dispatch, snooping AGU addresses and CDB store data.
// The head entry issues one memory access at a time; load results are held on a CDB port until granted.
module agu_lsq #(
  parameter int DEPTH    = 8,
  parameter int ROB_ID_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [1:0]          alloc_op,
  input  logic [ROB_ID_W-1:0] alloc_dest,
  input  logic [15:0]         alloc_data,
  input  logic                alloc_data_rdy,
  input  logic [ROB_ID_W-1:0] alloc_data_tag,
  output logic                full,
  input  logic                agu_valid,
  input  logic [ROB_ID_W-1:0] agu_dest,
  input  logic [15:0]         agu_addr,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_dest,
  input  logic [15:0]         cdb_value,
  input  logic                commit_store,
  input  logic [ROB_ID_W-1:0] commit_dest,
  output logic                mem_read,
  output logic                mem_write,
  output logic [15:0]         mem_addr,
  output logic [15:0]         mem_wdata,
  output logic [1:0]          mem_byte_en,
  input  logic                mem_resp,
  input  logic [15:0]         mem_rdata,
  output logic                ld_out_valid,
  output logic [ROB_ID_W-1:0] ld_out_dest,
  output logic [15:0]         ld_out_value,
  input  logic                ld_out_grant,
  input  logic                flush
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_BCAST, ST_DRAIN} state_e;

  // op encoding: bit1 set = store, bit0 set = byte access
  function automatic logic [1:0] lane_en(input logic is_byte, input logic a0);
    if (is_byte) lane_en = a0 ? 2'b10 : 2'b01;
    else         lane_en = 2'b11;
  endfunction

  function automatic logic [15:0] load_value(input logic is_byte, input logic [1:0] be,
                                             input logic [15:0] rd);
    logic [7:0] b;
    b = be[1] ? rd[15:8] : rd[7:0];
    load_value = is_byte ? {{8{b[7]}}, b} : rd;
  endfunction

  logic                valid_r    [DEPTH];
  logic [1:0]          op_r       [DEPTH];
  logic [ROB_ID_W-1:0] dest_r     [DEPTH];
  logic [15:0]         addr_r     [DEPTH];
  logic                addr_rdy_r [DEPTH];
  logic [15:0]         data_r     [DEPTH];
  logic                data_rdy_r [DEPTH];
  logic [ROB_ID_W-1:0] data_tag_r [DEPTH];

  logic [PTR_W-1:0] head_r, tail_r;
  logic [PTR_W:0]   count_r, count_nxt_s;
  logic             full_r;
  state_e           state_r, state_nxt_s;
  logic             issue_ld_s, issue_st_s, pop_s, accept_s, store_go_s;
  logic             mem_read_r, mem_write_r, req_byte_r, ld_out_valid_r;
  logic [15:0]      mem_addr_r, mem_wdata_r, ld_out_value_r;
  logic [1:0]       mem_byte_en_r;
  logic [ROB_ID_W-1:0] req_dest_r, ld_out_dest_r;

  logic                head_valid_s, head_addr_rdy_s, head_data_rdy_s;
  logic [1:0]          head_op_s;
  logic [ROB_ID_W-1:0] head_dest_s;
  logic [15:0]         head_addr_s, head_data_s;

  assign head_valid_s    = valid_r[head_r];
  assign head_addr_rdy_s = addr_rdy_r[head_r];
  assign head_data_rdy_s = data_rdy_r[head_r];
  assign head_op_s       = op_r[head_r];
  assign head_dest_s     = dest_r[head_r];
  assign head_addr_s     = addr_r[head_r];
  assign head_data_s     = data_r[head_r];

  assign store_go_s = head_addr_rdy_s && head_data_rdy_s && commit_store &&
                      (commit_dest == head_dest_s);
  // A full queue still accepts when the head pops in the same cycle
  assign accept_s   = alloc_valid && !flush && (!full_r || pop_s);

  // Next-state and issue/pop decisions
  always_comb begin
    state_nxt_s = state_r;
    issue_ld_s  = 1'b0;
    issue_st_s  = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush || !head_valid_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!head_op_s[1] && head_addr_rdy_s) begin
          issue_ld_s  = 1'b1;
          state_nxt_s = ST_MEM;
        end else if (head_op_s[1] && store_go_s) begin
          issue_st_s  = 1'b1;
          state_nxt_s = ST_MEM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (flush) begin
          state_nxt_s = mem_resp ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp) begin
          pop_s       = 1'b1;
          state_nxt_s = mem_read_r ? ST_BCAST : ST_IDLE;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_BCAST: begin
        if (flush || ld_out_grant) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_BCAST;
      end
      ST_DRAIN: begin
        if (mem_resp) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Occupancy after this cycle's allocate/pop
  always_comb begin
    count_nxt_s = count_r;
    if (accept_s && !pop_s)      count_nxt_s = count_r + 1'b1;
    else if (pop_s && !accept_s) count_nxt_s = count_r - 1'b1;
    else                         count_nxt_s = count_r;
  end

  // Queue storage, pointers and AGU/CDB snooping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]    <= 1'b0;
        op_r[i]       <= 2'b00;
        dest_r[i]     <= '0;
        addr_r[i]     <= 16'h0000;
        addr_rdy_r[i] <= 1'b0;
        data_r[i]     <= 16'h0000;
        data_rdy_r[i] <= 1'b0;
        data_tag_r[i] <= '0;
      end
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]    <= 1'b0;
        addr_rdy_r[i] <= 1'b0;
        data_rdy_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && !addr_rdy_r[i] && agu_valid && dest_r[i] == agu_dest) begin
          addr_r[i]     <= agu_addr;
          addr_rdy_r[i] <= 1'b1;
        end
        if (valid_r[i] && !data_rdy_r[i] && cdb_valid && data_tag_r[i] == cdb_dest) begin
          data_r[i]     <= cdb_value;
          data_rdy_r[i] <= 1'b1;
        end
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + 1'b1;
      end
      // Allocation is written last so it wins over a pop of the same slot when full
      if (accept_s) begin
        valid_r[tail_r]    <= 1'b1;
        op_r[tail_r]       <= alloc_op;
        dest_r[tail_r]     <= alloc_dest;
        addr_r[tail_r]     <= agu_addr;
        addr_rdy_r[tail_r] <= agu_valid && (agu_dest == alloc_dest);
        data_tag_r[tail_r] <= alloc_data_tag;
        if (!alloc_op[1]) begin
          data_r[tail_r]     <= 16'h0000;
          data_rdy_r[tail_r] <= 1'b1;
        end else if (alloc_data_rdy) begin
          data_r[tail_r]     <= alloc_data;
          data_rdy_r[tail_r] <= 1'b1;
        end else begin
          data_r[tail_r]     <= cdb_value;
          data_rdy_r[tail_r] <= cdb_valid && (cdb_dest == alloc_data_tag);
        end
        tail_r <= tail_r + 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Memory request: launched from the head, held until the response (also through DRAIN)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_addr_r    <= 16'h0000;
      mem_wdata_r   <= 16'h0000;
      mem_byte_en_r <= 2'b00;
      req_byte_r    <= 1'b0;
      req_dest_r    <= '0;
    end else if (issue_ld_s || issue_st_s) begin
      mem_read_r    <= issue_ld_s;
      mem_write_r   <= issue_st_s;
      mem_addr_r    <= {head_addr_s[15:1], 1'b0};
      mem_wdata_r   <= issue_st_s ? (head_op_s[0] ? {head_data_s[7:0], head_data_s[7:0]}
                                                   : head_data_s) : 16'h0000;
      mem_byte_en_r <= lane_en(head_op_s[0], head_addr_s[0]);
      req_byte_r    <= head_op_s[0];
      req_dest_r    <= head_dest_s;
    end else if ((state_r == ST_MEM || state_r == ST_DRAIN) && mem_resp) begin
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_addr_r    <= 16'h0000;
      mem_wdata_r   <= 16'h0000;
      mem_byte_en_r <= 2'b00;
    end
  end

  // Load result port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_out_valid_r <= 1'b0;
      ld_out_dest_r  <= '0;
      ld_out_value_r <= 16'h0000;
    end else if (flush) begin
      ld_out_valid_r <= 1'b0;
    end else if (state_r == ST_MEM && mem_resp && mem_read_r) begin
      ld_out_valid_r <= 1'b1;
      ld_out_dest_r  <= req_dest_r;
      ld_out_value_r <= load_value(req_byte_r, mem_byte_en_r, mem_rdata);
    end else if (state_r == ST_BCAST && ld_out_grant) begin
      ld_out_valid_r <= 1'b0;
    end
  end

  assign full         = full_r;
  assign mem_read     = mem_read_r;
  assign mem_write    = mem_write_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_byte_en  = mem_byte_en_r;
  assign ld_out_valid = ld_out_valid_r;
  assign ld_out_dest  = ld_out_dest_r;
  assign ld_out_value = ld_out_value_r;
endmodule

// File: doc/agu_lsq.md
Name: agu_lsq

Overview:
- In-order load/store queue directly downstream of the AGU reservation stations.
- Allocated at dispatch in program order; captures effective addresses broadcast by the AGU stage and store data from the CDB.
- Issues one memory access at a time from the head over a req/resp handshake; load results go out on a CDB port until granted.

Parameters:
DEPTH, 8, number of queue entries (power of two, >=2)
ROB_ID_W, 3, width of ROB id tags

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  allocate entry at tail this cycle
alloc_op  in  2  0=LDR, 1=LDB, 2=STR, 3=STB
alloc_dest  in  ROB_ID_W  ROB id of the instruction
alloc_data  in  16  store data value, valid if alloc_data_rdy
alloc_data_rdy  in  1  store data already available
alloc_data_tag  in  ROB_ID_W  producer ROB id when store data not ready
full  out  1  no free entry; alloc_valid ignored while high
agu_valid  in  1  AGU bus carries an address
agu_dest  in  ROB_ID_W  ROB id the address belongs to
agu_addr  in  16  effective address
cdb_valid  in  1  result bus broadcast valid
cdb_dest  in  ROB_ID_W  result bus tag
cdb_value  in  16  result bus value
commit_store  in  1  ROB head is a store and may retire
commit_dest  in  ROB_ID_W  ROB id of that store
mem_read  out  1  read request
mem_write  out  1  write request
mem_addr  out  16  word-aligned address (bit0 forced 0)
mem_wdata  out  16  write data
mem_byte_en  out  2  byte enables
mem_resp  in  1  access complete (one-cycle pulse)
mem_rdata  in  16  read data, valid with mem_resp
ld_out_valid  out  1  load result pending on CDB port
ld_out_dest  out  ROB_ID_W  ROB id of load
ld_out_value  out  16  load result
ld_out_grant  in  1  CDB accepted result this cycle
flush  in  1  discard all entries and pending work

Behaviour:
- Reset: head=tail=count=0; every entry's valid, addr_rdy and data_rdy cleared; state IDLE; full=0; mem_read=0, mem_write=0, ld_out_valid=0; all other outputs 0.
- Entry fields: valid, op, dest, addr, addr_rdy, data, data_rdy, data_tag.
- Allocation:
  - Entry written at tail on alloc_valid && !full; tail and count increment, wrapping modulo DEPTH.
  - Load entries get data_rdy=1.
  - full = (count==DEPTH).
- Address capture: each cycle, every valid entry with !addr_rdy and dest==agu_dest latches agu_addr and sets addr_rdy when agu_valid=1.
- Store data capture: every valid entry with !data_rdy and data_tag==cdb_dest latches cdb_value when cdb_valid=1.
- Same-cycle snoop: an entry allocated this cycle also snoops the AGU and CDB buses in that cycle, so a same-cycle broadcast is not lost.
- FSM states: IDLE, MEM, BCAST, DRAIN.
- IDLE, head valid:
  - Load with addr_rdy: assert mem_read, go to MEM.
  - Store with addr_rdy && data_rdy && commit_store && commit_dest==head.dest: assert mem_write, go to MEM.
- MEM:
  - mem_read/mem_write and mem_addr, mem_wdata, mem_byte_en are held stable until mem_resp.
  - On mem_resp for a store: pop head, go to IDLE.
  - On mem_resp for a load: latch the result, pop head, go to BCAST.
- BCAST: ld_out_valid=1, with dest and value held stable; on ld_out_grant go to IDLE. No new request starts in BCAST, so there is at most one outstanding result.
- Byte/word rules:
  - LDR/STR: byte_en=11, mem_addr=addr&~1.
  - LDB: byte_en selects addr[0] (addr[0]=0 -> 01, 1 -> 10); result = selected byte sign-extended to 16 bits.
  - STB: data[7:0] is replicated to both byte lanes; byte_en as for LDB.
- Pop and allocate in the same cycle: count is unchanged; this is legal even when full.
- Flush:
  - Clears all entries, head, tail and count the next cycle; ld_out_valid drops.
  - If flush arrives in MEM, the FSM goes to DRAIN and keeps the request asserted until mem_resp. The response is discarded, then the FSM goes to IDLE.
  - alloc_valid is ignored in the flush cycle.
  - Flush overrides grant and resp.
- Latency: a load issues the cycle after its address is captured at the head; its result is visible the cycle after mem_resp.

Test Plan:
- Basic load: alloc LDR dest=2; agu_dest=2, addr=0x3004; mem_resp with rdata=0xBEEF -> mem_read with mem_addr=0x3004, byte_en=11; then ld_out_valid, dest=2, value=0xBEEF until grant.
- LDB odd address: addr=0x1001, rdata=0x80FF -> byte_en=10, value=0xFF80.
- Store waits for data and commit: alloc STR dest=3, tag=5, addr ready.
  - No mem_write until cdb(5, 0x1234) arrives and commit_store with dest=3.
  - Then mem_wdata=0x1234, byte_en=11.
- Full/wrap: allocate DEPTH entries -> full=1 and the extra alloc is ignored; pop one with simultaneous alloc -> count stays DEPTH; tail wraps to 0.
- Out-of-order addresses: alloc loads A(dest 1) then B(dest 2); B's address arrives first -> no access until A's address arrives; A is issued first.
- Flush mid-access: flush while in MEM -> request held until mem_resp, no ld_out_valid, queue empty afterward, and full=0.
